// File: rtl/can_error_controller.sv
// can_error_controller: CAN fault confinement (TEC/REC, active/passive/bus-off) and error-frame sequencer
module can_error_controller #(
  parameter int FLAG_BITS   = 6,
  parameter int DELIM_BITS  = 8,
  parameter int RUN_BITS    = 11,
  parameter int BUSOFF_RUNS = 128
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_sample,
  input  logic       i_Data,
  input  logic       i_form_monitor,
  input  logic       i_bit_monitor,
  input  logic       i_stuff_monitor,
  input  logic       i_crc_monitor,
  input  logic       i_ack_monitor,
  input  logic       i_is_transmitter,
  input  logic       i_frame_ok,
  output logic       o_tx_bit,
  output logic       o_busy,
  output logic [1:0] o_error_state,
  output logic [8:0] o_tec,
  output logic [7:0] o_rec
);
  typedef enum logic [1:0] {IDLE, FLAG, WAIT_REC, DELIM} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt, run_cnt, runs;
  logic [8:0] tec_nxt;
  logic [7:0] rec_nxt;
  logic bus_off, flag_rec, passive, err, ok, off_set, run_done, recover;
  assign passive  = o_tec >= 9'd128 || o_rec >= 8'd128;
  assign err      = i_sample && state == IDLE && !bus_off &&
                    (i_form_monitor | i_bit_monitor | i_stuff_monitor | i_crc_monitor | i_ack_monitor);
  assign ok       = i_sample && state == IDLE && !bus_off && i_frame_ok && !err;
  assign off_set  = !bus_off && tec_nxt[8];
  assign run_done = bus_off && i_sample && i_Data && run_cnt == 8'(RUN_BITS - 1);
  assign recover  = run_done && runs == 8'(BUSOFF_RUNS - 1);
  always_comb begin
    tec_nxt = o_tec;
    rec_nxt = o_rec;
    if (err && i_is_transmitter) tec_nxt = o_tec >= 9'd504 ? 9'd511 : o_tec + 9'd8;
    if (err && !i_is_transmitter) rec_nxt = o_rec == 8'd255 ? o_rec : o_rec + 8'd1;
    if (ok && i_is_transmitter) tec_nxt = o_tec == 9'd0 ? o_tec : o_tec - 9'd1;
    if (ok && !i_is_transmitter) rec_nxt = o_rec == 8'd0 ? o_rec : o_rec - 8'd1;
  end
  always_ff @(posedge i_Clock)
    if (!i_Reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (off_set) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end else if (i_sample)
      case (state)
        IDLE: if (err) begin
          state_nxt = FLAG;
          cnt_nxt   = 8'd0;
        end
        FLAG: if (cnt == 8'(FLAG_BITS - 1)) begin
          state_nxt = WAIT_REC;
          cnt_nxt   = 8'd0;
        end else cnt_nxt = cnt + 8'd1;
        WAIT_REC: if (i_Data) begin
          state_nxt = DELIM;
          cnt_nxt   = 8'd1;
        end
        DELIM: if (!i_Data) begin
          state_nxt = WAIT_REC;
          cnt_nxt   = 8'd0;
        end else if (cnt == 8'(DELIM_BITS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else cnt_nxt = cnt + 8'd1;
      endcase
  end
  always_comb begin
    o_busy        = state != IDLE;
    o_tx_bit      = state == FLAG ? flag_rec : 1'b1;
    o_error_state = bus_off ? 2'b10 : passive ? 2'b01 : 2'b00;
  end
  // flag polarity is latched from the error state before the increment lands
  always_ff @(posedge i_Clock)
    if (!i_Reset_n) begin
      cnt      <= 8'd0;
      flag_rec <= 1'b0;
      o_tec    <= 9'd0;
      o_rec    <= 8'd0;
      bus_off  <= 1'b0;
      run_cnt  <= 8'd0;
      runs     <= 8'd0;
    end else begin
      cnt     <= cnt_nxt;
      o_tec   <= recover ? 9'd0 : tec_nxt;
      o_rec   <= recover ? 8'd0 : rec_nxt;
      bus_off <= recover ? 1'b0 : bus_off | tec_nxt[8];
      if (err) flag_rec <= passive;
      if (bus_off && i_sample) begin
        run_cnt <= (!i_Data || run_done) ? 8'd0 : run_cnt + 8'd1;
        runs    <= recover ? 8'd0 : run_done ? runs + 8'd1 : runs;
      end
    end
endmodule

// File: tb/tb_can_error_controller.sv
// tb_can_error_controller: directed vector table plus hand sequences for CAN error controller
module tb_can_error_controller;
  logic clk = 0, rst_n = 0, sample = 0, data = 1, tx = 0, ok = 0;
  logic [4:0] mon = 0;
  logic tx_bit, busy;
  logic [1:0] st;
  logic [8:0] tec;
  logic [7:0] rec;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst_n, sample, data;
    logic [4:0] mon;
    logic tx, ok, busy, tx_bit;
    logic [1:0] st;
    logic [8:0] tec;
    logic [7:0] rec;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  can_error_controller dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_sample(sample), .i_Data(data),
    .i_form_monitor(mon[4]), .i_bit_monitor(mon[3]), .i_stuff_monitor(mon[2]),
    .i_crc_monitor(mon[1]), .i_ack_monitor(mon[0]), .i_is_transmitter(tx),
    .i_frame_ok(ok), .o_tx_bit(tx_bit), .o_busy(busy), .o_error_state(st),
    .o_tec(tec), .o_rec(rec)
  );
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic cyc(input logic r, s, d, input logic [4:0] m, input logic t, o);
    @(negedge clk);
    rst_n = r; sample = s; data = d; mon = m; tx = t; ok = o;
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic d, input logic [4:0] m, input logic t, input logic o);
    cyc(1, 1, d, m, t, o);
  endtask
  task automatic err_frame(input logic t, input logic [4:0] m);
    smp(0, m, t, 0);
    repeat (6) smp(0, 0, t, 0);
    repeat (8) smp(1, 0, t, 0);
  endtask
  task automatic add(input logic r, s, d, input logic [4:0] m, input logic t, o, b, x,
                     input logic [1:0] e, input logic [8:0] te, input logic [7:0] re);
    vq.push_back('{r, s, d, m, t, o, b, x, e, te, re});
  endtask
  initial begin
    add(0, 0, 1, 5'b00000, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 5'b00000, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 5'b10000, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 5'b10000, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, i == 1 ? 5'b01000 : 5'b00000, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1);
    add(1, 1, 0, 5'b00000, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(1, 1, 1, 5'b00000, 0, 0, 1, 1, 0, 0, 1);
    add(1, 1, 1, 5'b00000, 0, 0, 0, 1, 0, 0, 1);
    add(1, 1, 0, 5'b10010, 0, 1, 1, 0, 0, 0, 2);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 5'b00000, 0, 0, 1, i == 5, 0, 0, 2);
    for (int i = 0; i < 8; i++) add(1, 1, 1, 5'b00000, 0, 0, i != 7, 1, 0, 0, 2);
    add(1, 0, 1, 5'b00000, 0, 1, 0, 1, 0, 0, 2);
    add(1, 1, 1, 5'b00000, 0, 1, 0, 1, 0, 0, 1);
    add(1, 1, 1, 5'b00000, 1, 1, 0, 1, 0, 0, 1);
    add(1, 1, 1, 5'b00000, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 5'b00000, 0, 1, 0, 1, 0, 0, 0);
    foreach (vq[i]) begin
      cyc(vq[i].rst_n, vq[i].sample, vq[i].data, vq[i].mon, vq[i].tx, vq[i].ok);
      chk($sformatf("vec%0d_busy", i), busy, vq[i].busy);
      chk($sformatf("vec%0d_tx_bit", i), tx_bit, vq[i].tx_bit);
      chk($sformatf("vec%0d_state", i), st, vq[i].st);
      chk($sformatf("vec%0d_tec", i), tec, vq[i].tec);
      chk($sformatf("vec%0d_rec", i), rec, vq[i].rec);
    end
    // delimiter interrupted by a dominant bit restarts from scratch
    smp(0, 5'b00100, 0, 0);
    chk("delim_err_rec", rec, 1);
    repeat (6) smp(0, 0, 0, 0);
    repeat (3) smp(1, 0, 0, 0);
    chk("delim_3_busy", busy, 1);
    smp(0, 0, 0, 0);
    chk("delim_dom_busy", busy, 1);
    repeat (7) smp(1, 0, 0, 0);
    chk("delim_fresh7_busy", busy, 1);
    smp(1, 0, 0, 0);
    chk("delim_fresh8_busy", busy, 0);
    // transmitter climbs to error-passive
    repeat (15) err_frame(1, 5'b01000);
    chk("tec120", tec, 120);
    chk("tec120_state", st, 0);
    smp(0, 5'b01000, 1, 0);
    chk("act_flag_tx_bit", tx_bit, 0);
    chk("tec128", tec, 128);
    chk("tec128_state", st, 1);
    repeat (6) smp(0, 0, 1, 0);
    repeat (8) smp(1, 0, 1, 0);
    chk("tec128_idle", busy, 0);
    smp(0, 5'b00001, 1, 0);
    chk("pas_flag_tx_bit", tx_bit, 1);
    chk("pas_flag_busy", busy, 1);
    chk("tec136", tec, 136);
    repeat (6) smp(0, 0, 1, 0);
    repeat (8) smp(1, 0, 1, 0);
    repeat (14) err_frame(1, 5'b00010);
    chk("tec248", tec, 248);
    chk("tec248_state", st, 1);
    // bus-off entry and recovery
    smp(0, 5'b01000, 1, 0);
    chk("busoff_tec", tec, 256);
    chk("busoff_state", st, 2);
    chk("busoff_busy", busy, 0);
    chk("busoff_tx_bit", tx_bit, 1);
    smp(0, 5'b11111, 1, 1);
    chk("busoff_ign_tec", tec, 256);
    chk("busoff_ign_rec", rec, 1);
    chk("busoff_ign_busy", busy, 0);
    for (int r = 0; r < 64; r++) repeat (11) smp(1, r == 0 ? 5'b11111 : 5'b00000, 1, r == 0);
    chk("recov_mid_tec", tec, 256);
    chk("recov_mid_state", st, 2);
    repeat (5) smp(1, 0, 1, 0);
    smp(0, 0, 1, 0);
    repeat (703) smp(1, 0, 1, 0);
    chk("recov_before_last", st, 2);
    smp(1, 0, 1, 0);
    chk("recov_state", st, 0);
    chk("recov_tec", tec, 0);
    chk("recov_rec", rec, 0);
    // reset during the error flag
    smp(0, 5'b10000, 1, 0);
    chk("rstflag_busy", busy, 1);
    chk("rstflag_tec", tec, 8);
    smp(0, 0, 1, 0);
    smp(0, 0, 1, 0);
    cyc(0, 1, 0, 5'b10000, 1, 0);
    chk("rst_tx_bit", tx_bit, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tec", tec, 0);
    chk("rst_rec", rec, 0);
    chk("rst_state", st, 0);
    smp(0, 0, 1, 0);
    chk("post_rst_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_error_controller.md
Name: can_error_controller

Overview:
Fault-confinement and error-frame sequencer for the CAN node. Collects per-bit error pulses from the form, bit, stuff, CRC and ACK monitors and drives the 6-bit error flag and the 8-bit delimiter onto the TX path. Maintains the TEC/REC counters and the error-active / error-passive / bus-off state, including bus-off recovery. Sits between the error monitors and the bit transmitter; o_busy tells the frame decoder to abandon the current frame.

Parameters:
FLAG_BITS, 6, error flag length in bit times
DELIM_BITS, 8, error delimiter length in recessive bit times
RUN_BITS, 11, recessive bits per bus-off recovery run
BUSOFF_RUNS, 128, recessive runs required to leave bus-off

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  reset, active-low, synchronous
i_sample  in  1  one-cycle strobe at each bit sample point
i_Data  in  1  sampled bus bit (1 = recessive), valid when i_sample=1
i_form_monitor, i_bit_monitor, i_stuff_monitor, i_crc_monitor, i_ack_monitor  in  1 each  error flags from the monitors
i_is_transmitter  in  1  1 = node owns the current frame
i_frame_ok  in  1  one-cycle pulse at successful end of frame
o_tx_bit  out  1  bit to drive (1 = recessive)
o_busy  out  1  error frame in progress
o_error_state  out  2  00 active, 01 passive, 10 bus-off
o_tec  out  9  transmit error count
o_rec  out  8  receive error count

Behaviour:
- Reset (i_Reset_n=0 at a clock edge): state IDLE, o_tx_bit=1, o_busy=0, o_tec=0, o_rec=0, o_error_state=00, all internal counters 0. Reset mid-error-frame aborts it immediately.
- All FSM and counter activity advances only on cycles with i_sample=1. The exception is reset.
- Error event: i_sample=1, FSM in IDLE, not bus-off, and the OR of the five monitors equals 1.
  - Several monitors in the same cycle produce one event.
  - Monitors asserted outside IDLE are ignored.
- Error event and i_frame_ok in the same cycle: the error wins and i_frame_ok is dropped.
- Counter updates are registered; the new value is visible the cycle after the event.
  - On an error, TEC += 8 if i_is_transmitter, else REC += 1.
  - On i_frame_ok in IDLE, TEC -= 1 if i_is_transmitter, else REC -= 1.
  - Both counters saturate: TEC at 0 and 511, REC at 0 and 255.
- o_error_state is combinational from the registered counters and the bus-off flag:
  - bus-off if the flag is set;
  - else passive if TEC>=128 or REC>=128;
  - else active.
- The bus-off flag sets in the cycle TEC becomes >=256.
- FSM states: IDLE, FLAG, WAIT_REC, DELIM.
  - IDLE -> FLAG on an error event. The next cycle has o_busy=1 and a cleared bit counter. o_tx_bit=0 if the pre-increment state was active; o_tx_bit=1 if it was passive.
  - FLAG: count each sample. On the FLAG_BITS-th sample go to WAIT_REC with o_tx_bit=1.
  - WAIT_REC: on a sample with i_Data=1 go to DELIM with count=1. Dominant samples keep the FSM waiting with no timeout.
  - DELIM: a recessive sample increments the count. When the count reaches DELIM_BITS, go to IDLE with o_busy=0. A dominant sample returns to WAIT_REC.
- Bus-off entry in any state forces IDLE, o_tx_bit=1 and o_busy=0.
- Bus-off recovery, on samples only:
  - a recessive sample increments run_cnt;
  - when run_cnt reaches RUN_BITS, run_cnt resets to 0 and runs increments;
  - a dominant sample clears run_cnt and leaves runs unchanged.
- When runs reaches BUSOFF_RUNS: TEC=0, REC=0, bus-off flag and runs cleared. The state is active on the next cycle.
- Monitors and i_frame_ok are ignored in bus-off.

Test Plan:
- Reset, then i_form_monitor=1 on one sample as receiver -> next cycle o_busy=1, o_tx_bit=0, o_rec=1; 6 samples dominant; then 8 recessive samples -> o_busy=0 and IDLE after the 8th sample.
- Transmitter with TEC=120, bit error -> flag is dominant (pre-increment state active), o_tec=128, o_error_state=01. The next error's flag is recessive.
- Form and CRC monitors together with i_frame_ok in the same sample -> a single event: REC +1 only, no decrement.
- In DELIM after 3 recessive samples, inject a dominant sample -> back to WAIT_REC. The delimiter then needs 8 fresh recessive samples.
- TEC=248 plus a transmitter error -> o_tec=256, o_error_state=10, o_tx_bit=1, monitors ignored. 128×11 recessive samples with one dominant sample mid-run (that run restarts) -> TEC=REC=0, state 00.
- i_Reset_n low during FLAG -> next cycle o_tx_bit=1, o_busy=0, counters 0.
